// File: rtl/sram_ctrl.sv
// Pipeline MEM-stage bridge to a 16-bit asynchronous SRAM: each 32-bit access is split into a low
// and a high half-word phase. Define SRAM_ADDR_CHECK_EN to reject misaligned or out-of-range addresses.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYCLES);

  state_t      state;
  logic [2:0]  cnt;
  logic        op_wr;
  logic [16:0] idx_q;
  logic [31:0] data_q;
  logic        req;
  logic [16:0] idx;
  logic        bad_addr;

  assign req = wr_en | rd_en;
  assign idx = 17'((address - BASE_ADDR) >> 2);

  // The stall is visible in the same cycle the request appears, so the pipeline freezes before the edge.
  assign ready = (state == IDLE) ? ~req : (state == DONE);

`ifdef SRAM_ADDR_CHECK_EN
  logic [12:0] idx_hi;
  logic        addr_err_q;

  assign idx_hi   = 13'((address - BASE_ADDR) >> 19);
  assign bad_addr = (address < BASE_ADDR) | (address[1:0] != 2'b00) | (idx_hi != '0);
  assign addr_err = addr_err_q;
`else
  assign bad_addr = 1'b0;
  assign addr_err = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
`ifdef SRAM_ADDR_CHECK_EN
      addr_err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr  <= wr_en;
            idx_q  <= idx;
            data_q <= write_data;
            if (bad_addr) begin
              state <= DONE;
`ifdef SRAM_ADDR_CHECK_EN
              addr_err_q <= 1'b1;
`endif
            end else begin
              state       <= LOW;
              cnt         <= CNT_LOAD;
              sram_addr   <= {idx, 1'b0};
              sram_dq_out <= write_data[15:0];
              sram_dq_oe  <= wr_en;
              sram_we_n   <= ~wr_en;
`ifdef SRAM_ADDR_CHECK_EN
              addr_err_q  <= 1'b0;
`endif
            end
          end
        end

        LOW: begin
          if (cnt == 3'd0) begin
            if (!op_wr) read_data[15:0] <= sram_dq_in;
            state       <= HIGH;
            cnt         <= CNT_LOAD;
            sram_addr   <= {idx_q, 1'b1};
            sram_dq_out <= data_q[31:16];
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        HIGH: begin
          if (cnt == 3'd0) begin
            if (!op_wr) read_data[31:16] <= sram_dq_in;
            state      <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        // Leave unconditionally so a request still held during DONE is not issued twice.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
